// File: rtl/msk_prng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msk_prng_pkg
// Description : Shared constants, FSM state type and single-step LFSR helper
//               for the masked-gadget randomness source.
//               LFSR_W     - state width (64)
//               TAP_*      - feedback tap positions of the maximal polynomial
//               ZERO_SUB   - substitute state loaded when the seed is zero
//               prng_state_e - IDLE / WARM / RUN
// Revision    : 1.0 - initial release
// ============================================================================
package msk_prng_pkg;

  localparam int LFSR_W = 64;

  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  // An all-zero state is the single lock-up point of the LFSR.
  localparam logic [LFSR_W-1:0] ZERO_SUB = 64'hF000_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } prng_state_e;

  // One Fibonacci step: feedback enters at bit 0, so bit 0 is the newest bit.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic f;
    f = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-2:0], f};
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_lfsr_unroll.sv
`default_nettype none
// ============================================================================
// Module      : msk_lfsr_unroll
// Description : Purely combinational N_RND-fold unrolled LFSR step.
// Ports       : state_i [63:0] - current LFSR state
//               state_o [63:0] - state after N_RND consecutive steps
// Parameters  : N_RND          - number of chained steps (1..64)
// Revision    : 1.0 - initial release
// ============================================================================
module msk_lfsr_unroll
  import msk_prng_pkg::*;
#(
  parameter int N_RND = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] w_chain [0:N_RND];

  assign w_chain[0] = state_i;

  for (genvar i = 0; i < N_RND; i++) begin : g_step
    assign w_chain[i+1] = lfsr_step(w_chain[i]);
  end

  assign state_o = w_chain[N_RND];

endmodule
`default_nettype wire

// File: rtl/msk_rnd_prng.sv
`default_nettype none
// ============================================================================
// Module      : msk_rnd_prng
// Description : Seeded 64-bit LFSR randomness source feeding the masked
//               refresh / multiplication gadgets. Accepts a seed over a
//               valid/ready handshake, warms up for WARM_CYCLES cycles, then
//               produces N_RND fresh bits per enabled cycle.
// Ports       : clk         in   clock, rising edge
//               rst_n       in   asynchronous active-low reset
//               seed        in   64-bit seed (zero is replaced by ZERO_SUB)
//               seed_valid  in   seed offered
//               seed_ready  out  seed accepted when seed_valid && seed_ready
//               en          in   request a new word (honoured in RUN only)
//               rnd_out     out  random word, 0 while rnd_valid is low
//               rnd_valid   out  rnd_out usable
//               reseed_req  out  reseed requested
// Config      : MSK_PRNG_RESEED_REQ_EN - compiles in the output-step counter
//               that raises reseed_req after 2^RESEED_LOG2 enabled steps;
//               when undefined reseed_req is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module msk_rnd_prng
  import msk_prng_pkg::*;
#(
  parameter int N_RND       = 8,
  parameter int WARM_CYCLES = 16,
  parameter int RESEED_LOG2 = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              en,
  output logic [N_RND-1:0]  rnd_out,
  output logic              rnd_valid,
  output logic              reseed_req
);

  // Elaboration-time parameter legality.
  if (N_RND < 1 || N_RND > LFSR_W) begin : g_bad_n_rnd
    $error("msk_rnd_prng: N_RND must be in 1..64");
  end
  if (WARM_CYCLES < 1) begin : g_bad_warm
    $error("msk_rnd_prng: WARM_CYCLES must be >= 1");
  end
  if (RESEED_LOG2 < 1) begin : g_bad_reseed
    $error("msk_rnd_prng: RESEED_LOG2 must be >= 1");
  end

  localparam int              WCW         = $clog2(WARM_CYCLES + 1);
  localparam logic [WCW-1:0]  c_WARM_LAST = WCW'(WARM_CYCLES - 1);

  prng_state_e       state_q;
  logic [LFSR_W-1:0] s_q;
  logic [LFSR_W-1:0] s_adv_d;
  logic [WCW-1:0]    warm_cnt_q;
  logic              valid_q;
  logic              seed_ready_q;
  logic              w_seed_acc;

  msk_lfsr_unroll #(
    .N_RND (N_RND)
  ) u_unroll (
    .state_i (s_q),
    .state_o (s_adv_d)
  );

  assign w_seed_acc = seed_valid & seed_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= ZERO_SUB;
      warm_cnt_q   <= '0;
      valid_q      <= 1'b0;
      seed_ready_q <= 1'b1;
    end else if (w_seed_acc) begin
      // A seed accepted in RUN overrides a concurrent en: load unstepped.
      state_q      <= ST_WARM;
      s_q          <= (seed == '0) ? ZERO_SUB : seed;
      warm_cnt_q   <= '0;
      valid_q      <= 1'b0;
      seed_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WARM: begin
          s_q        <= s_adv_d;
          warm_cnt_q <= warm_cnt_q + 1'b1;
          if (warm_cnt_q == c_WARM_LAST) begin
            state_q      <= ST_RUN;
            valid_q      <= 1'b1;
            seed_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (en) begin
            s_q <= s_adv_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign seed_ready = seed_ready_q;
  assign rnd_valid  = valid_q;
  assign rnd_out    = valid_q ? s_q[N_RND-1:0] : '0;

`ifdef MSK_PRNG_RESEED_REQ_EN
  // MSB of the step counter doubles as the saturation flag and reseed_req.
  localparam int RCW = RESEED_LOG2 + 1;

  logic [RCW-1:0] rcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
    end else if (w_seed_acc) begin
      rcnt_q <= '0;
    end else if (state_q == ST_RUN && en && !rcnt_q[RESEED_LOG2]) begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign reseed_req = rcnt_q[RESEED_LOG2];
`else
  assign reseed_req = 1'b0;
`endif

endmodule
`default_nettype wire
